// File: rtl/memctl_pkg.sv
// Shared types and constants for the multi-channel memory arbiter.
// The state encoding is 3 bits wide so it can be exported on the debug port as is.
package memctl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Saturating increment so the timeout counter can never wrap back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and bus signals of the memory arbiter, bundled into one interface.
// The arbiter connects through 'master'; requesters plus the bus model use 'slave'.
interface mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*BE_W-1:0]   ch_be;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     ch_err;
  logic [DATA_W-1:0]        ch_rdata;

  logic                     bus_read;
  logic                     bus_write;
  logic [ADDR_W-1:0]        bus_addr;
  logic [DATA_W-1:0]        bus_wdata;
  logic [BE_W-1:0]          bus_be;
  logic [DATA_W-1:0]        bus_rdata;
  logic                     bus_busy;

  modport master (
    input  ch_req, ch_we, ch_addr, ch_wdata, ch_be, bus_rdata, bus_busy,
    output ch_ack, ch_err, ch_rdata, bus_read, bus_write, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    output ch_req, ch_we, ch_addr, ch_wdata, ch_be, bus_rdata, bus_busy,
    input  ch_ack, ch_err, ch_rdata, bus_read, bus_write, bus_addr, bus_wdata, bus_be
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational channel picker: round-robin starting after the last winner,
// or fixed priority where the lowest active index wins.
module rr_arbiter
  import memctl_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = ARB_RR
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_winner,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] winner
);
  localparam int IDX_W = $clog2(NUM_CH);

  int   base_idx;
  int   scan_idx;
  logic found;

  // Scan NUM_CH slots from the start point, wrapping once; the first active request wins.
  always_comb begin
    grant    = '0;
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    base_idx = (RR_MODE == ARB_RR) ? int'(last_winner) + 1 : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = base_idx + k;
      if (scan_idx >= NUM_CH) begin
        scan_idx = scan_idx - NUM_CH;
      end
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        winner          = IDX_W'(scan_idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory controller: arbitrates NUM_CH requesters onto one bus port
// with byte enables, a bus timeout and fully registered outputs.
module mem_arbiter
  import memctl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = ARB_RR,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master port_if,
  output logic [2:0]    state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_CH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_winner;
  logic [15:0]       cnt_inc;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req         (port_if.ch_req),
    .last_winner (last_q),
    .grant       (arb_grant),
    .winner      (arb_winner)
  );

  assign cnt_inc = sat_inc16(cnt_q);

  // Strobes and acks default low so each is a single-cycle pulse in the state that follows.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    bus_read_d  = 1'b0;
    bus_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|port_if.ch_req) begin
          state_d     = GRANT;
          winner_d    = arb_winner;
          grant_d     = arb_grant;
          we_d        = port_if.ch_we[arb_winner];
          addr_d      = port_if.ch_addr[int'(arb_winner)*ADDR_W +: ADDR_W];
          wdata_d     = port_if.ch_wdata[int'(arb_winner)*DATA_W +: DATA_W];
          be_d        = port_if.ch_be[int'(arb_winner)*BE_W +: BE_W];
          bus_read_d  = ~port_if.ch_we[arb_winner];
          bus_write_d = port_if.ch_we[arb_winner];
        end
      end

      GRANT: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        if (!port_if.bus_busy) begin
          state_d = DONE;
          err_d   = 1'b0;
          ack_d   = grant_q;
          if (!we_q) begin
            rdata_d = port_if.bus_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= 16'(TIMEOUT_CYC)) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            ack_d   = grant_q;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        last_d  = winner_q;
        err_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset mid-transfer simply discards everything: no ack or strobe is ever produced for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      last_q      <= IDX_W'(NUM_CH - 1);
      grant_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= '0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
    end
  end

  assign port_if.ch_ack    = ack_q;
  assign port_if.ch_err    = err_q;
  assign port_if.ch_rdata  = rdata_q;
  assign port_if.bus_read  = bus_read_q;
  assign port_if.bus_write = bus_write_q;
  assign port_if.bus_addr  = addr_q;
  assign port_if.bus_wdata = wdata_q;
  assign port_if.bus_be    = be_q;
  assign state             = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin arbiter (timeout 4) driven step by step, plus a
// fixed-priority twin fed the same requests for the arbitration-order check.
module tb_mem_arbiter;
  import memctl_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_a;
  logic [2:0] state_b;
  int         total = 0;
  int         bad   = 0;

  mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  mem_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(ARB_RR), .TIMEOUT_CYC(4)
  ) dut_rr (
    .clk     (clk),
    .rst     (rst),
    .port_if (ifa),
    .state   (state_a)
  );

  mem_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(ARB_FIXED), .TIMEOUT_CYC(4)
  ) dut_fixed (
    .clk     (clk),
    .rst     (rst),
    .port_if (ifb),
    .state   (state_b)
  );

  assign ifb.ch_req    = ifa.ch_req;
  assign ifb.ch_we     = ifa.ch_we;
  assign ifb.ch_addr   = ifa.ch_addr;
  assign ifb.ch_wdata  = ifa.ch_wdata;
  assign ifb.ch_be     = ifa.ch_be;
  assign ifb.bus_rdata = '0;
  assign ifb.bus_busy  = 1'b0;

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
    ifa.ch_req[ch]               = 1'b1;
    ifa.ch_we[ch]                = we;
    ifa.ch_addr[ch*AW +: AW]     = addr;
    ifa.ch_wdata[ch*DW +: DW]    = wdata;
    ifa.ch_be[ch*(DW/8) +: DW/8] = be;
  endtask

  initial begin
    logic [2:0] exp_order [6];
    int         got;
    int         stray_acks;

    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst            = 1'b0;
    ifa.ch_req     = '0;
    ifa.ch_we      = '0;
    ifa.ch_addr    = '0;
    ifa.ch_wdata   = '0;
    ifa.ch_be      = '0;
    ifa.bus_rdata  = '0;
    ifa.bus_busy   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_state", state_a, IDLE);
    check_output("rst_state_fixed", state_b, IDLE);
    check_output("rst_ack", ifa.ch_ack, 3'b000);
    check_output("rst_err", ifa.ch_err, 1'b0);
    check_output("rst_rdata", ifa.ch_rdata, 32'h0);
    check_output("rst_bus_read", ifa.bus_read, 1'b0);
    check_output("rst_bus_write", ifa.bus_write, 1'b0);
    check_output("rst_bus_addr", ifa.bus_addr, 32'h0);
    rst = 1'b1;

    // Single zero-wait read on channel 1
    @(negedge clk);
    apply_stimulus(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    ifa.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("rd_strobe", ifa.bus_read, 1'b1);
    check_output("rd_no_write", ifa.bus_write, 1'b0);
    check_output("rd_addr", ifa.bus_addr, 32'h40);
    check_output("rd_grant_state", state_a, GRANT);
    @(negedge clk);
    check_output("rd_wait_state", state_a, WAIT);
    check_output("rd_strobe_once", ifa.bus_read, 1'b0);
    check_output("rd_no_early_ack", ifa.ch_ack, 3'b000);
    @(negedge clk);
    check_output("rd_ack", ifa.ch_ack, 3'b010);
    check_output("rd_rdata", ifa.ch_rdata, 32'hDEAD_BEEF);
    check_output("rd_err", ifa.ch_err, 1'b0);
    ifa.ch_req = '0;
    @(negedge clk);
    check_output("rd_idle_state", state_a, IDLE);
    check_output("rd_ack_pulse", ifa.ch_ack, 3'b000);
    check_output("rd_idle_addr", ifa.bus_addr, 32'h0);
    check_output("rd_rdata_held", ifa.ch_rdata, 32'hDEAD_BEEF);

    // Write on channel 0 with three wait states
    apply_stimulus(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    check_output("wr_strobe", ifa.bus_write, 1'b1);
    check_output("wr_no_read", ifa.bus_read, 1'b0);
    check_output("wr_be", ifa.bus_be, 4'b0011);
    check_output("wr_wdata", ifa.bus_wdata, 32'h1234_5678);
    ifa.bus_busy = 1'b1;
    @(negedge clk);
    check_output("wr_strobe_once", ifa.bus_write, 1'b0);
    repeat (2) @(negedge clk);
    check_output("wr_addr_held", ifa.bus_addr, 32'h100);
    @(negedge clk);
    check_output("wr_still_wait", state_a, WAIT);
    check_output("wr_no_early_ack", ifa.ch_ack, 3'b000);
    ifa.bus_busy = 1'b0;
    @(negedge clk);
    check_output("wr_ack", ifa.ch_ack, 3'b001);
    check_output("wr_err", ifa.ch_err, 1'b0);
    check_output("wr_rdata_kept", ifa.ch_rdata, 32'hDEAD_BEEF);
    ifa.ch_req = '0;
    @(negedge clk);

    // Channel 1 changes its address while the transfer waits
    apply_stimulus(1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    ifa.bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ifa.bus_busy = 1'b1;
    @(negedge clk);
    ifa.ch_addr[1*AW +: AW] = 32'hFFFF_0000;
    @(negedge clk);
    check_output("mid_addr_held", ifa.bus_addr, 32'h80);
    ifa.bus_busy = 1'b0;
    @(negedge clk);
    check_output("mid_ack", ifa.ch_ack, 3'b010);
    check_output("mid_rdata", ifa.ch_rdata, 32'hCAFE_F00D);
    check_output("mid_addr_done", ifa.bus_addr, 32'h80);
    ifa.ch_req = '0;
    @(negedge clk);

    // Bus stuck busy on a channel 2 read: error completion after 4 wait cycles
    apply_stimulus(2, 1'b0, 32'h0000_000C, 32'h0, 4'hF);
    ifa.bus_rdata = 32'h5555_5555;
    @(negedge clk);
    ifa.bus_busy = 1'b1;
    repeat (4) @(negedge clk);
    check_output("to_still_wait", state_a, WAIT);
    check_output("to_no_early_ack", ifa.ch_ack, 3'b000);
    @(negedge clk);
    check_output("to_ack", ifa.ch_ack, 3'b100);
    check_output("to_err", ifa.ch_err, 1'b1);
    check_output("to_rdata", ifa.ch_rdata, 32'h0);
    check_output("to_done_state", state_a, DONE);
    ifa.ch_req   = '0;
    ifa.bus_busy = 1'b0;
    @(negedge clk);
    check_output("to_idle_state", state_a, IDLE);
    check_output("to_err_clear", ifa.ch_err, 1'b0);
    repeat (3) @(negedge clk);

    // All three channels request continuously
    for (int c = 0; c < NCH; c++) begin
      apply_stimulus(c, 1'b0, 32'h1000 + 32'(c), 32'h0, 4'hF);
    end
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (ifa.ch_ack != 3'b000) begin
        check_output("rr_order", ifa.ch_ack, exp_order[got]);
        check_output("fixed_order", ifb.ch_ack, 3'b001);
        got++;
      end
    end
    check_output("rr_ack_count", got, 6);
    ifa.ch_req = '0;
    repeat (3) @(negedge clk);

    // Reset asserted while a channel 0 read waits on the bus
    apply_stimulus(0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    @(negedge clk);
    ifa.bus_busy = 1'b1;
    @(negedge clk);
    check_output("rw_wait_state", state_a, WAIT);
    #2 rst = 1'b0;
    #1;
    check_output("rw_async_state", state_a, IDLE);
    check_output("rw_async_addr", ifa.bus_addr, 32'h0);
    check_output("rw_async_ack", ifa.ch_ack, 3'b000);
    ifa.ch_req   = '0;
    ifa.bus_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stray_acks = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (ifa.ch_ack != 3'b000) stray_acks++;
    end
    check_output("rw_no_ack", stray_acks, 0);
    apply_stimulus(1, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    ifa.bus_rdata = 32'h1122_3344;
    @(negedge clk);
    check_output("rw_next_strobe", ifa.bus_read, 1'b1);
    check_output("rw_next_addr", ifa.bus_addr, 32'h44);
    repeat (2) @(negedge clk);
    check_output("rw_next_ack", ifa.ch_ack, 3'b010);
    check_output("rw_next_rdata", ifa.ch_rdata, 32'h1122_3344);
    ifa.ch_req = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
